// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: widths, bit placement, nibble encoder and encoder FSM states.
package hamming_pkg;

    localparam int unsigned CW_W   = 7;
    localparam int unsigned DATA_W = 4;

    localparam int unsigned PAR_IDX  [3] = '{0, 1, 3};
    localparam int unsigned DATA_IDX [4] = '{2, 4, 5, 6};

    typedef enum logic [1:0] {
        StIdle,
        StSendLo,
        StSendHi
    } enc_state_e;

    function automatic logic [CW_W-1:0] encode_nibble(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            c[DATA_IDX[i]] = d[i];
        end
        c[PAR_IDX[0]] = d[0] ^ d[1] ^ d[3];
        c[PAR_IDX[1]] = d[0] ^ d[2] ^ d[3];
        c[PAR_IDX[2]] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

endpackage

// File: rtl/hamming74_nibble_enc.sv
// Combinational Hamming(7,4) encoder for one nibble.
module hamming74_nibble_enc
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CW_W-1:0]   code
);

    assign code = encode_nibble(data);

endmodule

// File: rtl/hamming74_byte_encoder.sv
// Byte-wide Hamming(7,4) transmit encoder: two codewords per byte, low nibble first,
// with optional single-bit error injection and a wrapping codeword counter.
module hamming74_byte_encoder
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             err_en,
    input  logic [3:0]       err_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW_W-1:0]  out_code,
    output logic             out_hi,
    output logic [CNT_W-1:0] cw_count
);

    enc_state_e       state_q;
    logic [CW_W-1:0]  hi_code_q;
    logic [CW_W-1:0]  lo_cw;
    logic [CW_W-1:0]  hi_cw;
    logic [CW_W-1:0]  lo_mask;
    logic [CW_W-1:0]  hi_mask;
    logic [2:0]       hi_idx;
    logic             accept;
    logic             out_fire;

    hamming74_nibble_enc u_enc_lo (
        .data (in_data[3:0]),
        .code (lo_cw)
    );

    hamming74_nibble_enc u_enc_hi (
        .data (in_data[7:4]),
        .code (hi_cw)
    );

    // err_pos 0-6 targets the low word, 7-13 the high word, 14-15 nothing.
    always_comb begin
        lo_mask = '0;
        hi_mask = '0;
        hi_idx  = 3'(err_pos - 4'd7);
        if (err_en) begin
            if (err_pos < 4'd7) begin
                lo_mask[err_pos[2:0]] = 1'b1;
            end else if (err_pos < 4'd14) begin
                hi_mask[hi_idx] = 1'b1;
            end
        end
    end

    // Gated by rst_n so upstream never sees ready while the block is held in reset.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            in_ready = (state_q == StIdle) || ((state_q == StSendHi) && out_ready);
        end
    end

    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            hi_code_q <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_hi    <= 1'b0;
            cw_count  <= '0;
        end else begin
            if (out_fire) begin
                cw_count <= cw_count + CNT_W'(1);
            end
            if (accept) begin
                state_q   <= StSendLo;
                out_code  <= lo_cw ^ lo_mask;
                hi_code_q <= hi_cw ^ hi_mask;
                out_hi    <= 1'b0;
                out_valid <= 1'b1;
            end else begin
                case (state_q)
                    StSendLo: begin
                        if (out_ready) begin
                            state_q  <= StSendHi;
                            out_code <= hi_code_q;
                            out_hi   <= 1'b1;
                        end
                    end
                    StSendHi: begin
                        if (out_ready) begin
                            state_q   <= StIdle;
                            out_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hamming74_byte_encoder.sv
// Self-checking bench for hamming74_byte_encoder against a position-based Hamming model.
module tb_hamming74_byte_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        err_en;
    logic [3:0]  err_pos;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_code;
    logic        out_hi;
    logic [15:0] cw_count;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    typedef struct {
        logic [6:0] code;
        logic       hi;
        logic       clean;
        logic [3:0] nib;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_cnt = '0;

    hamming74_byte_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .err_en    (err_en),
        .err_pos   (err_pos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_hi    (out_hi),
        .cw_count  (cw_count)
    );

    always #5 clk = ~clk;

    // Classic Hamming layout: bit index i is position i+1; powers of two hold parity.
    function automatic logic [6:0] model_enc(input logic [3:0] d);
        logic [6:0] c;
        int k;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 4; p = p * 2) begin
            logic par;
            par = 1'b0;
            for (int pos = 1; pos <= 7; pos++) begin
                if ((pos & p) != 0 && pos != p) par ^= c[pos-1];
            end
            c[p-1] = par;
        end
        return c;
    endfunction

    function automatic logic [2:0] model_syn(input logic [6:0] c);
        logic [2:0] s;
        s = '0;
        for (int b = 0; b < 3; b++) begin
            for (int pos = 1; pos <= 7; pos++) begin
                if ((pos & (1 << b)) != 0) s[b] ^= c[pos-1];
            end
        end
        return s;
    endfunction

    function automatic logic [3:0] model_dec(input logic [6:0] c);
        return {c[6], c[5], c[4], c[2]};
    endfunction

    // Outstanding words: 0 = idle, 2 = low word showing, 1 = high word showing.
    function automatic logic model_in_ready();
        if (!rst_n) return 1'b0;
        if (exp_q.size() == 0) return 1'b1;
        if (exp_q.size() == 1) return out_ready;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            model_cnt = '0;
        end else begin
            logic       hs;
            logic       acc;
            logic [13:0] w;
            logic       flip;
            hs   = (exp_q.size() != 0) && out_ready;
            acc  = in_valid && model_in_ready();
            if (hs) begin
                void'(exp_q.pop_front());
                model_cnt = model_cnt + 16'd1;
            end
            if (acc) begin
                w    = {model_enc(in_data[7:4]), model_enc(in_data[3:0])};
                flip = err_en && (err_pos < 4'd14);
                if (flip) w[err_pos] = ~w[err_pos];
                exp_q.push_back('{code: w[6:0], hi: 1'b0,
                                  clean: !(flip && err_pos < 4'd7), nib: in_data[3:0]});
                exp_q.push_back('{code: w[13:7], hi: 1'b1,
                                  clean: !(flip && err_pos >= 4'd7), nib: in_data[7:4]});
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (run_cmp) begin
            check("in_ready", 32'(in_ready), 32'(model_in_ready()));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("out_code", 32'(out_code), 32'(exp_q[0].code));
                check("out_hi", 32'(out_hi), 32'(exp_q[0].hi));
                if (exp_q[0].clean) begin
                    check("syndrome", 32'(model_syn(out_code)), 32'd0);
                    check("decode", 32'(model_dec(out_code)), 32'(exp_q[0].nib));
                end
            end
            check("cw_count", 32'(cw_count), 32'(model_cnt));
        end
    end

    task automatic send_expect(input logic [7:0] data, input logic en, input logic [3:0] pos,
                               input logic [6:0] exp_lo, input logic [6:0] exp_hi,
                               input string tag);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = data;
        err_en    = en;
        err_pos   = pos;
        out_ready = 1'b1;
        #1 check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        err_en   = 1'b0;
        #1;
        check({tag, " lo code"}, 32'(out_code), 32'(exp_lo));
        check({tag, " lo hi"}, 32'(out_hi), 32'd0);
        if (en && pos < 4'd7)
            check({tag, " lo syndrome nonzero"}, 32'(model_syn(out_code) != 3'd0), 32'd1);
        @(negedge clk);
        #1;
        check({tag, " hi code"}, 32'(out_code), 32'(exp_hi));
        check({tag, " hi hi"}, 32'(out_hi), 32'd1);
        if (en && pos >= 4'd7 && pos < 4'd14)
            check({tag, " hi syndrome nonzero"}, 32'(model_syn(out_code) != 3'd0), 32'd1);
        @(negedge clk);
        #1 check({tag, " idle valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain done", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic accepted;
        int   waited;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; err_en = 1'b0; err_pos = '0;
        out_ready = 1'b0;

        // Model pinned to hand-computed codewords.
        check("model enc 5", 32'(model_enc(4'h5)), 32'h2D);
        check("model enc B", 32'(model_enc(4'hB)), 32'h55);
        check("model enc F", 32'(model_enc(4'hF)), 32'h7F);
        for (int n = 0; n < 16; n++) begin
            check("model syndrome", 32'(model_syn(model_enc(4'(n)))), 32'd0);
        end

        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_code", 32'(out_code), 32'd0);
        check("reset out_hi", 32'(out_hi), 32'd0);
        check("reset cw_count", 32'(cw_count), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        run_cmp = 1'b1;

        send_expect(8'hB5, 1'b0, 4'd0, 7'h2D, 7'h55, "B5");
        check("count after B5", 32'(cw_count), 32'd2);

        // Back-to-back 0x00 then 0xFF.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
        @(negedge clk);
        in_data = 8'hFF;
        #1 check("b2b w0", 32'(out_code), 32'h00);
        @(negedge clk);
        #1 check("b2b w1", 32'(out_code), 32'h00);
        check("b2b in_ready send_hi 1", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("b2b w2", 32'(out_code), 32'h7F);
        @(negedge clk);
        #1 check("b2b w3", 32'(out_code), 32'h7F);
        check("b2b in_ready send_hi 2", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Downstream stall on the low word.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hB5; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall code", 32'(out_code), 32'h2D);
            check("stall in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("stall release lo", 32'(out_code), 32'h2D);
        @(negedge clk);
        #1 check("stall release hi", 32'(out_code), 32'h55);
        @(negedge clk);

        send_expect(8'hB5, 1'b1, 4'd2, 7'h29, 7'h55, "inj2");
        send_expect(8'hB5, 1'b1, 4'd13, 7'h2D, 7'h15, "inj13");
        send_expect(8'hB5, 1'b1, 4'd15, 7'h2D, 7'h55, "inj15");
        check("count after directed", 32'(cw_count), 32'd14);

        // Exhaustive bytes with random backpressure.
        for (int b = 0; b < 256; b++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'(b); err_en = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            waited = 0;
            while (!in_ready && waited < 100) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
                #1;
                waited++;
            end
            if (!in_ready) begin
                check("exhaustive accept timeout", 32'd0, 32'd1);
                break;
            end
        end
        drain();
        check("count after exhaustive", 32'(cw_count), 32'd526);

        // Random bytes, injection, gaps and backpressure.
        accepted = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_data  = 8'($urandom);
                err_en   = 1'($urandom_range(0, 1));
                err_pos  = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1 accepted = in_valid && in_ready;
        end
        drain();

        // Reset while the high word is showing.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h3C; err_en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        #1 check("pre-reset hi", 32'(out_hi), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset cw_count", 32'(cw_count), 32'd0);
        check("mid reset in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post reset in_ready", 32'(in_ready), 32'd1);
        check("post reset out_valid", 32'(out_valid), 32'd0);

        send_expect(8'hB5, 1'b0, 4'd0, 7'h2D, 7'h55, "after reset");
        check("count after reset", 32'(cw_count), 32'd2);

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming74_byte_encoder.md
Name: hamming74_byte_encoder

Overview:
- Transmit-side Hamming(7,4) encoder feeding the error_correction block downstream.
- Accepts one byte per valid/ready handshake and emits two registered 7-bit codewords, low nibble first, on a valid/ready output.
- Includes a per-byte single-bit error-injection path for loopback testing of the corrector, plus a wrapping codeword counter.

Parameters:
- CNT_W, 16, width of emitted-codeword counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte available.
- in_ready  out  1  encoder can accept byte this cycle.
- in_data  in  8  byte to encode.
- err_en  in  1  inject one bit flip into this byte's codewords (sampled with in_data).
- err_pos  in  4  0-6 flip bit err_pos of low codeword; 7-13 flip bit (err_pos-7) of high codeword; 14-15 no flip.
- out_valid  out  1  codeword valid.
- out_ready  in  1  downstream accepts codeword.
- out_code  out  7  codeword, bit order defined below.
- out_hi  out  1  0 = low-nibble codeword, 1 = high-nibble codeword.
- cw_count  out  CNT_W  count of accepted output codewords, wraps modulo 2^CNT_W.

Behaviour:
- Codeword map for nibble d[3:0]:
  - c[2]=d0, c[4]=d1, c[5]=d2, c[6]=d3.
  - c[0]=d0^d1^d3, c[1]=d0^d2^d3, c[3]=d1^d2^d3.
  - The result satisfies syndrome s0=c6^c4^c2^c0, s1=c6^c5^c2^c1, s2=c6^c5^c4^c3 all zero.
- FSM states: IDLE, SEND_LO, SEND_HI.
- Reset (async assert, sync release): state=IDLE; out_valid=0, out_code=0, out_hi=0, cw_count=0; in_ready=0 while rst_n low.
- in_ready is combinational: 1 in IDLE; 1 in SEND_HI when out_ready=1; otherwise 0.
- Input handshake: in_valid & in_ready.
  - Latch both codewords with the injection flip already applied.
  - Next state SEND_LO; out_code=low codeword; out_hi=0; out_valid=1.
- Latency: byte accepted at edge N, low codeword presented after edge N.
- SEND_LO: hold out_code/out_hi stable while out_ready=0. On out_ready: go to SEND_HI, present the high codeword with out_hi=1.
- SEND_HI with out_ready:
  - If in_valid, accept the new byte in the same cycle and go to SEND_LO.
  - Else go to IDLE with out_valid=0.
  - Sustained throughput is one byte per 2 cycles with no bubble.
- Output stability: out_valid never drops without a handshake; out_code never changes while out_valid=1 and out_ready=0.
- in_valid in SEND_LO or SEND_HI without out_ready: ignored, no accept, byte held by upstream.
- cw_count increments by 1 on every out_valid & out_ready and wraps from all-ones to 0.
- Injection: exactly zero or one bit flipped per byte. err_en=0 means no flip regardless of err_pos. err_pos 14/15 with err_en=1 means no flip.
- Reset mid-transfer: pending codewords are discarded, and the downstream sees out_valid fall asynchronously.

Decomposition:
- Shared package hamming_pkg:
  - CW_W=7, DATA_W=4.
  - Parity-bit indices {0,1,3} and data-bit indices {2,4,5,6}.
  - Function encode_nibble (4 -> 7).
  - FSM state enum.
- One natural sub-module, hamming74_nibble_enc: purely combinational, instantiated twice. The top block holds the FSM, registers, injection and counter.

Test Plan:
- Reset, then in_data=0xB5, out_ready=1 -> out_code 0x2D (out_hi=0), then 0x55 (out_hi=1); cw_count=2.
- Bytes 0x00 and 0xFF back-to-back, out_ready=1 -> codewords 0x00, 0x00, 0x7F, 0x7F on consecutive cycles; in_ready high in each SEND_HI cycle.
- 0xB5 with out_ready=0 for 5 cycles -> out_code held at 0x2D, in_ready=0; after release, sequence completes unchanged.
- 0xB5 with err_en=1, err_pos=2 -> 0x29, then 0x55. With err_pos=13 -> 0x2D, then 0x15. With err_pos=15 -> 0x2D, 0x55. Each flipped word fed to error_correction yields a nonzero syndrome.
- Exhaustive 256 bytes, random out_ready -> every codeword has a zero syndrome and decodes back to its nibble; cw_count=512.
- rst_n pulsed low while in SEND_HI -> out_valid=0 immediately, cw_count=0, state IDLE, in_ready=1 after release.
